// File: rtl/oam_dma_ctrl_pkg.sv
// oam_dma_ctrl_pkg: shared address constants, index width and FSM state type for the OAM DMA controller.
// ALIGN only exists when OAM_DMA_ALIGN_EN is defined.
package oam_dma_ctrl_pkg;
  localparam logic [15:0] DEFAULT_DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;
  localparam int IDX_WIDTH = 8;
  typedef enum logic [2:0] {
    IDLE,
    HALT,
`ifdef OAM_DMA_ALIGN_EN
    ALIGN,
`endif
    READ,
    WRITE
  } dma_state_t;
endpackage

// File: rtl/oam_dma_bus_mux.sv
// oam_dma_bus_mux: hands the memory bus to the CPU in IDLE and to the DMA FSM otherwise.
module oam_dma_bus_mux import oam_dma_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(DEFAULT_OAM_DATA_ADDR)
) (
  input  dma_state_t             state,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [REG_WIDTH-1:0]   cpu_dout,
  input  logic                   cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]   page,
  input  logic [IDX_WIDTH-1:0]   index,
  input  logic [REG_WIDTH-1:0]   data_q,
  output logic [ADDR_WIDTH-1:0]  bus_addr,
  output logic [REG_WIDTH-1:0]   bus_dout,
  output logic                   bus_r_w_n,
  output logic                   rdy,
  output logic                   dma_busy
);
  logic idle, rd, wr;
  always_comb begin
    idle = state == IDLE;
    rd = state == READ;
    wr = state == WRITE;
    // HALT and ALIGN fall through to a dummy read of whatever the CPU is addressing
    bus_addr = idle ? cpu_addr : wr ? OAM_DATA_ADDR : rd ? ADDR_WIDTH'({page, index}) : cpu_addr;
    bus_dout = idle ? cpu_dout : data_q;
    bus_r_w_n = idle ? cpu_r_w_n : !wr;
    rdy = idle;
    dma_busy = !idle;
  end
endmodule

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: halts the CPU and copies one 256-byte page to the OAM data port.
// OAM_DMA_ALIGN_EN adds a parity flop and an ALIGN cycle when HALT lands on an odd cycle.
module oam_dma_ctrl import oam_dma_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = ADDR_WIDTH'(DEFAULT_DMA_REG_ADDR),
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(DEFAULT_OAM_DATA_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]  bus_din,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_dout,
  output logic                  bus_r_w_n,
  output logic                  rdy,
  output logic                  dma_busy,
  output logic                  dma_done
);
  dma_state_t state, state_n;
  logic [REG_WIDTH-1:0] page, data_q;
  logic [IDX_WIDTH-1:0] index;
  logic trigger, last;
  assign trigger = !cpu_r_w_n && cpu_addr == DMA_REG_ADDR;
  assign last = index == '1;
`ifdef OAM_DMA_ALIGN_EN
  logic parity;
  always_ff @(posedge clk) parity <= reset ? 1'b0 : !parity;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = trigger ? HALT : IDLE;
`ifdef OAM_DMA_ALIGN_EN
      HALT:  state_n = parity ? ALIGN : READ;
      ALIGN: state_n = READ;
`else
      HALT:  state_n = READ;
`endif
      READ:  state_n = WRITE;
      WRITE: state_n = last ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      page <= '0;
      index <= '0;
      data_q <= '0;
      dma_done <= 1'b0;
    end else begin
      state <= state_n;
      dma_done <= state == WRITE && last;
      if (state == IDLE && trigger) begin
        page <= cpu_dout;
        index <= '0;
      end
      if (state == READ) data_q <= bus_din;
      // index never carries into page; the transfer simply ends at 8'hFF
      if (state == WRITE && !last) index <= index + 1'b1;
    end
  end
  oam_dma_bus_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_WIDTH(REG_WIDTH),
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_mux (
    .state(state),
    .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout),
    .cpu_r_w_n(cpu_r_w_n),
    .page(page),
    .index(index),
    .data_q(data_q),
    .bus_addr(bus_addr),
    .bus_dout(bus_dout),
    .bus_r_w_n(bus_r_w_n),
    .rdy(rdy),
    .dma_busy(dma_busy)
  );
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: self-checking bench for oam_dma_ctrl with a byte-array memory and a transfer-level model.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] cpu_addr, bus_addr;
  logic [7:0] cpu_dout, bus_din, bus_dout;
  logic cpu_r_w_n, bus_r_w_n, rdy, dma_busy, dma_done;
  logic [7:0] mem [0:65535];
  logic [7:0] wq [$];
  logic [15:0] rq [$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {
    logic [15:0] addr;
    logic [7:0] dout;
    logic rw;
    logic [15:0] e_addr;
    logic [7:0] e_dout;
    logic e_rw;
    logic e_rdy;
    logic e_busy;
  } vec_t;

  always #5 clk = ~clk;
  assign bus_din = mem[bus_addr];
  // cycles since reset; its LSB is the expected parity of the current cycle
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_r_w_n(cpu_r_w_n), .bus_din(bus_din), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_r_w_n(bus_r_w_n), .rdy(rdy),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] pg, input bit hp, input bit retrig, input int rst_at);
    int exp_dummy, lowcnt, seq_err, nwr, early_done, post_wr, i;
    logic [7:0] exp_data [$];
    logic [15:0] ea;
    logic er;
    lowcnt = 0; seq_err = 0; nwr = 0; early_done = 0; post_wr = 0;
`ifdef OAM_DMA_ALIGN_EN
    exp_dummy = 1 + int'(hp);
`else
    exp_dummy = 1;
`endif
    wq.delete();
    rq.delete();
    for (int n = 0; n < 256; n++) exp_data.push_back(mem[{pg, 8'(n)}]);
    @(negedge clk);
    if ((cyc % 2) == int'(hp)) @(negedge clk);
    cpu_addr = 16'h4014; cpu_dout = pg; cpu_r_w_n = 1'b0;
    #1;
    check("trig_pass_addr", bus_addr, 16'h4014);
    check("trig_pass_rw", bus_r_w_n, 1'b0);
    check("trig_pass_rdy", rdy, 1'b1);
    @(negedge clk);
    cpu_addr = 16'h0123; cpu_dout = 8'h00; cpu_r_w_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      #1;
      if (rdy) break;
      lowcnt++;
      if (dma_done) early_done++;
      if (k < exp_dummy) begin
        ea = cpu_addr; er = 1'b1;
      end else begin
        i = (k - exp_dummy) / 2;
        ea = ((k - exp_dummy) % 2 == 0) ? {pg, 8'(i)} : 16'h2004;
        er = (k - exp_dummy) % 2 == 0;
        if (er) rq.push_back(bus_addr);
        else begin
          wq.push_back(bus_dout);
          if (bus_dout !== exp_data[i]) seq_err++;
        end
      end
      if (bus_addr !== ea || bus_r_w_n !== er || dma_busy !== 1'b1) seq_err++;
      if (!bus_r_w_n && bus_addr == 16'h2004) nwr++;
      if (rst_at > 0 && nwr == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_abort_rdy", rdy, 1'b1);
        check("rst_abort_busy", dma_busy, 1'b0);
        check("rst_abort_done", dma_done, 1'b0);
        check("rst_abort_bus", bus_addr, cpu_addr);
        check("rst_abort_seq", seq_err, 0);
        reset = 1'b0;
        repeat (20) begin
          @(negedge clk);
          #1;
          if (!bus_r_w_n && bus_addr == 16'h2004) post_wr++;
        end
        check("rst_no_more_writes", post_wr, 0);
        return;
      end
      if (retrig && k == 50) begin
        cpu_addr = 16'h4014; cpu_dout = 8'h03; cpu_r_w_n = 1'b0;
      end
      if (retrig && k == 53) begin
        cpu_addr = 16'h0123; cpu_dout = 8'h00; cpu_r_w_n = 1'b1;
      end
      @(negedge clk);
    end
    check("rdy_low_cycles", lowcnt, exp_dummy + 512);
    check("bus_sequence", seq_err, 0);
    check("write_count", nwr, 256);
    check("done_at_end", dma_done, 1'b1);
    check("done_early", early_done, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", dma_done, 1'b0);
    check("idle_after", dma_busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'h1234, 8'hAA, 1'b0, 16'h1234, 8'hAA, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h4014, 8'h55, 1'b1, 16'h4014, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h4015, 8'h02, 1'b0, 16'h4015, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h2004, 8'h77, 1'b0, 16'h2004, 8'h77, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h4013, 8'h01, 1'b0, 16'h4013, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{16'h0200, 8'hC3, 1'b1, 16'h0200, 8'hC3, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 65536; n++) mem[n] = 8'(n * 7 + 3);
    reset = 1'b1; cpu_addr = 16'hABCD; cpu_dout = 8'h05; cpu_r_w_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdy", rdy, 1'b1);
    check("reset_busy", dma_busy, 1'b0);
    check("reset_done", dma_done, 1'b0);
    check("reset_bus_addr", bus_addr, 16'hABCD);
    check("reset_bus_dout", bus_dout, 8'h05);
    check("reset_bus_rw", bus_r_w_n, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      cpu_addr = tbl[n].addr; cpu_dout = tbl[n].dout; cpu_r_w_n = tbl[n].rw;
      #1;
      check("tbl_addr", bus_addr, tbl[n].e_addr);
      check("tbl_dout", bus_dout, tbl[n].e_dout);
      check("tbl_rw", bus_r_w_n, tbl[n].e_rw);
      check("tbl_rdy", rdy, tbl[n].e_rdy);
      check("tbl_busy", dma_busy, tbl[n].e_busy);
    end
    @(negedge clk);
    cpu_r_w_n = 1'b1;
    #1;
    check("tbl_no_trigger", dma_busy, 1'b0);

    for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'h5A;
    xfer(8'h02, 1'b0, 1'b0, 0);
    check("basic_first_data", wq[0], 8'h5A);
    check("basic_second_data", wq[1], 8'h5B);
    check("basic_last_data", wq[255], 8'hA5);
    check("basic_first_read", rq[0], 16'h0200);

    xfer(8'h02, 1'b1, 1'b0, 0);

    xfer(8'hFF, 1'b0, 1'b0, 0);
    check("pageff_first_read", rq[0], 16'hFF00);
    check("pageff_last_read", rq[255], 16'hFFFF);

    xfer(8'h02, 1'b0, 1'b1, 0);
    check("retrig_last_read", rq[255], 16'h02FF);

    xfer(8'h02, 1'b0, 1'b0, 100);

    for (int t = 0; t < 4; t++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      for (int n = 0; n < 256; n++) mem[{pg, 8'(n)}] = 8'($urandom);
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        cpu_addr = 16'($urandom);
        if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
        cpu_dout = 8'($urandom);
        cpu_r_w_n = 1'($urandom_range(0, 1));
        #1;
        check("rand_pass_addr", bus_addr, cpu_addr);
        check("rand_pass_dout", bus_dout, cpu_dout);
        check("rand_pass_rw", bus_r_w_n, cpu_r_w_n);
        check("rand_pass_busy", dma_busy, 1'b0);
      end
      xfer(pg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
